// File: rtl/parking_request_gen_pkg.sv
// Shared types and constants for the parking-lot request front end.
package parking_pkg;

    localparam int unsigned NUM_SLOTS  = 4;
    localparam int unsigned SLOT_IDX_W = 2;

    // Bit positions inside the pending vector {exit[3:0], enter}
    localparam int unsigned ENTER_IDX  = 0;
    localparam int unsigned EXIT_BASE  = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        COOLDOWN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/parking_request_gen_if.sv
// Request/status bundle between the front end (master) and the parking-lot controller (slave).
interface parking_request_gen_if;
    import parking_pkg::*;

    logic                    enter;
    logic                    exit;
    logic [SLOT_IDX_W-1:0]   exitLocation;
    logic [NUM_SLOTS-1:0]    occupancy;
    logic                    is_full;
    logic [NUM_SLOTS:0]      pending;
    logic                    dropped;

    modport master (
        output enter, exit, exitLocation, pending, dropped,
        input  occupancy, is_full
    );

    modport slave (
        input  enter, exit, exitLocation, pending, dropped,
        output occupancy, is_full
    );

endinterface

// File: rtl/parking_request_gen_button_debouncer.sv
// One button: 2-flop synchroniser, stability counter and rising-edge pulse of the debounced level.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          lvl;
    logic          lvl_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync  <= '0;
            cnt   <= '0;
            lvl   <= 1'b0;
            lvl_q <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            lvl_q <= lvl;
            if (sync[1] == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                lvl <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/parking_request_gen.sv
// Button front end for the parking controller: debounced presses become pending requests, issued one at a time.
// Optional build macro PARKING_EXIT_FILTER_EN discards exits aimed at unoccupied slots.
module parking_request_gen
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned COOLDOWN_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   btn_enter,
    input  logic [NUM_SLOTS-1:0]   btn_exit,
    parking_request_gen_if.master  req
);

    localparam int unsigned     CDW    = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [CDW-1:0]  CD_MAX = CDW'(COOLDOWN_CYCLES - 1);

    logic [NUM_SLOTS:0]      set_vec;
    logic [NUM_SLOTS:0]      pending_q;
    logic [NUM_SLOTS-1:0]    exit_pend;
    logic [NUM_SLOTS-1:0]    clr_exit;
    logic                    clr_enter;

    arb_state_t              state, state_d;
    logic [CDW-1:0]          cd_cnt, cd_d;
    logic                    sel_exit_q, sel_exit_d;
    logic [SLOT_IDX_W-1:0]   sel_slot_q, sel_slot_d;
    logic [SLOT_IDX_W-1:0]   rr_ptr, rr_d;
    logic [SLOT_IDX_W-1:0]   probe, cand;
    logic                    found, pick;
    logic                    enter_o, exit_o, dropped_o;
    logic [SLOT_IDX_W-1:0]   loc_o;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_enter),
        .rise  (set_vec[ENTER_IDX])
    );

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_exit_db
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_exit (
            .clk   (clk),
            .reset (reset),
            .btn   (btn_exit[i]),
            .rise  (set_vec[EXIT_BASE + i])
        );
    end

    assign exit_pend = pending_q[EXIT_BASE +: NUM_SLOTS];

    always_comb begin
        state_d    = state;
        cd_d       = cd_cnt;
        sel_exit_d = sel_exit_q;
        sel_slot_d = sel_slot_q;
        rr_d       = rr_ptr;
        clr_exit   = '0;
        clr_enter  = 1'b0;
        enter_o    = 1'b0;
        exit_o     = 1'b0;
        loc_o      = '0;
        dropped_o  = 1'b0;
        pick       = 1'b0;
        found      = 1'b0;
        cand       = '0;
        probe      = '0;

        case (state)
            IDLE: pick = 1'b1;
            ISSUE: begin
                if (sel_exit_q) begin
                    exit_o             = 1'b1;
                    loc_o              = sel_slot_q;
                    clr_exit[sel_slot_q] = 1'b1;
                    rr_d               = sel_slot_q + 1'b1;
                end else begin
                    enter_o   = 1'b1;
                    clr_enter = 1'b1;
                end
                state_d = COOLDOWN;
                cd_d    = '0;
            end
            COOLDOWN: begin
                if (cd_cnt == CD_MAX) begin
                    state_d = IDLE;
                    pick    = 1'b1;
                end else begin
                    cd_d = cd_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            probe = rr_ptr + SLOT_IDX_W'(k);
            if (!found && exit_pend[probe]) begin
                found = 1'b1;
                cand  = probe;
            end
        end

        // The last cooldown cycle doubles as the IDLE decision so back-to-back
        // requests are spaced COOLDOWN_CYCLES+1 apart; discards only happen in IDLE
        // so that cooldown cycles keep every output low.
        if (pick) begin
            if (found) begin
`ifdef PARKING_EXIT_FILTER_EN
                if (!req.occupancy[cand]) begin
                    if (state == IDLE) begin
                        clr_exit[cand] = 1'b1;
                        dropped_o      = 1'b1;
                    end
                    state_d = IDLE;
                end else
`endif
                begin
                    sel_exit_d = 1'b1;
                    sel_slot_d = cand;
                    state_d    = ISSUE;
                end
            end else if (pending_q[ENTER_IDX]) begin
                if (req.is_full) begin
                    if (state == IDLE) begin
                        clr_enter = 1'b1;
                        dropped_o = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    sel_exit_d = 1'b0;
                    sel_slot_d = '0;
                    state_d    = ISSUE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cd_cnt     <= '0;
            sel_exit_q <= 1'b0;
            sel_slot_q <= '0;
            rr_ptr     <= '0;
            pending_q  <= '0;
        end else begin
            state      <= state_d;
            cd_cnt     <= cd_d;
            sel_exit_q <= sel_exit_d;
            sel_slot_q <= sel_slot_d;
            rr_ptr     <= rr_d;
            // A new press landing on the bit being served keeps it pending
            pending_q  <= (pending_q & ~{clr_exit, clr_enter}) | set_vec;
        end
    end

    assign req.enter        = enter_o;
    assign req.exit         = exit_o;
    assign req.exitLocation = loc_o;
    assign req.pending      = pending_q;
    assign req.dropped      = dropped_o;

endmodule

// File: doc/parking_request_gen.md
Name: parking_request_gen

Overview:
- Front end that drives the parking-lot controller's request interface: `enter`, `exit` and `exitLocation`.
- Takes raw mechanical buttons (one entry button, four per-slot exit buttons), then synchronises, debounces and edge-detects them.
- Holds each press as a pending request and issues legal single-cycle requests, one at a time.
- Never asserts `enter` and `exit` together, and spaces requests by a cooldown so the controller's occupancy and full status settle between them.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required before a debounced level changes (min 2).
- COOLDOWN_CYCLES, 2: idle cycles forced after every issued request (min 1).
- NUM_SLOTS, 4: parking slots. Fixed at 4; `exitLocation` is 2 bits.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- btn_enter  in  1  raw entry button, asynchronous, bouncy
- btn_exit  in  4  raw exit buttons, bit i = slot i, asynchronous, bouncy
- occupancy  in  4  controller occupancy vector, bit i = slot i taken
- is_full  in  1  controller full flag
- enter  out  1  single-cycle entry request
- exit  out  1  single-cycle exit request
- exitLocation  out  2  slot index, valid while `exit`=1, else 0
- pending  out  5  {exit[3:0], enter} pending-request flags
- dropped  out  1  single-cycle pulse when a pending request is discarded

Behaviour:
- Reset (reset=0 at a clk edge): `enter`, `exit`, `exitLocation`, `pending`, `dropped` all 0.
  - Synchronisers, debounced levels and counters are cleared.
  - Arbiter goes to IDLE; the round-robin pointer is set to slot 0.
  - Reset mid-request or mid-cooldown aborts it; no output pulse survives reset.
- Synchroniser: each button passes through 2 flops.
- Debouncer, per button:
  - Counter is cleared while the synchronised value equals the debounced level.
  - Counter increments while they differ.
  - On reaching DEBOUNCE_CYCLES-1 with the values still differing, the debounced level takes the new value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Edge detect: a rising edge of a debounced level sets its pending bit on the next cycle. Release edges are ignored.
- Merging: a press while the same pending bit is already set is merged (no second request).
- Arbiter states:
  - IDLE: if any pending bit is set, select one request and move to ISSUE.
  - ISSUE: exactly one cycle.
    - Drive `enter`=1, or `exit`=1 with `exitLocation`=slot.
    - Clear the served pending bit.
    - Go to COOLDOWN.
  - COOLDOWN: outputs low for COOLDOWN_CYCLES cycles, then IDLE.
- Selection priority:
  - Exits beat enter, so a freed slot is visible first.
  - Among exits, round-robin starting at the slot after the last issued exit; the pointer updates only on an issued exit.
- Full condition: if enter is selected while `is_full`=1, the enter pending bit is cleared, `dropped` pulses for 1 cycle, the arbiter returns to IDLE, and no `enter` is issued.
- Simultaneous set and serve of the same pending bit in one cycle: the set wins, and the bit remains pending.
- Latency from an idle arbiter, DEBOUNCE_CYCLES=4: the output pulse is on the 8th rising edge after the button is first sampled high.
  - 2 synchroniser cycles
  - DEBOUNCE_CYCLES debounce cycles
  - 1 pending cycle
  - 1 issue cycle
- Output invariant: `enter` & `exit` is always 0.

Optional Feature:
- Macro: PARKING_EXIT_FILTER_EN.
- Defined: when an exit for slot i is selected and `occupancy[i]`=0, it is discarded instead of issued.
  - Pending bit i is cleared and `dropped` pulses.
  - The arbiter returns to IDLE; the round-robin pointer is unchanged.
- Undefined: exits are issued regardless of `occupancy`, and `dropped` is asserted only by the full condition.

Decomposition:
- Shared package parking_pkg holds:
  - the arbiter state enum (IDLE, ISSUE, COOLDOWN)
  - NUM_SLOTS
  - SLOT_IDX_W=2
  - the pending-vector index constants (ENTER_IDX=0, EXIT_BASE=1)
- One sub-module, button_debouncer (2-flop synchroniser + debounce counter + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated 5 times.
- Arbiter and pending register live in parking_request_gen.

Test Plan:
- btn_enter held high from cycle 0, is_full=0 -> `enter`=1 for exactly one cycle on edge 8, then 2 cycles low; `pending`=0 afterwards.
- btn_exit[2] toggling every cycle for 3 cycles, then low -> no `exit`, `pending` stays 0.
- btn_enter and btn_exit[1] pressed on the same cycle, occupancy=4'b0010 -> `exit` with `exitLocation`=1 first, then `enter` exactly COOLDOWN_CYCLES+1 cycles later.
- btn_exit = 4'b1111 pressed together, pointer at 0, occupancy=4'b1111 -> exits issued in slot order 0,1,2,3, each separated by 3 cycles.
- btn_enter pressed with is_full=1 -> `dropped` pulses once, `enter` never asserted, pending[0] cleared.
- PARKING_EXIT_FILTER_EN defined, btn_exit[3] pressed with occupancy=4'b0111 -> `dropped` pulses, no `exit`.
- Same stimulus with the macro undefined -> `exit`=1 with `exitLocation`=3.
- reset=0 asserted during COOLDOWN with enter pending -> all outputs 0 next cycle; no request issued after release until a new press.
